up_down_counter_param: RTL and testbench
========================================

Name: up_down_counter_param

Overview:
Parametrised successor to the team's fixed 4-bit up/down counter. Adds:
- configurable width and modulus;
- count enable;
- synchronous parallel load;
- wrap or saturate mode at the limits;
- a registered terminal-count pulse.

Used as a reusable event/position counter in lab datapaths (BCD digits, timers, position trackers).

Parameters:
- WIDTH, 4, count register width in bits (>=1).
- MAX_VAL, 2**WIDTH-1, upper count limit; legal range 1..2**WIDTH-1; count range is 0..MAX_VAL.
- SAT_MODE, 0, 0 = wrap at limits, 1 = saturate (hold) at limits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; no counting when low.
- up_down  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count (registered).
- tc  output  1  registered terminal-count pulse.
- at_max  output  1  combinational, count == MAX_VAL.
- at_min  output  1  combinational, count == 0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All state updates on the rising edge of clk.
- Reset values: count = 0, tc = 0. Hence at_min = 1 and at_max = 0 during and after reset.
- Priority per edge: reset > load > en. up_down is ignored when en = 0 or load = 1.
- load = 1: count <= min(load_val, MAX_VAL); tc <= 0. Out-of-range load values clamp to MAX_VAL.
- load = 0, en = 0: count holds; tc <= 0.
- load = 0, en = 1, up_down = 1:
  - count < MAX_VAL: count <= count + 1; tc <= 0.
  - count == MAX_VAL, SAT_MODE = 0: count <= 0; tc <= 1.
  - count == MAX_VAL, SAT_MODE = 1: count holds at MAX_VAL; tc <= 1.
- load = 0, en = 1, up_down = 0:
  - count > 0: count <= count - 1; tc <= 0.
  - count == 0, SAT_MODE = 0: count <= MAX_VAL; tc <= 1.
  - count == 0, SAT_MODE = 1: count holds at 0; tc <= 1.
- tc is a one-cycle pulse per boundary event. It is high in the cycle following the edge at which the event occurred.
  - In saturate mode with en held high at a limit, tc re-asserts every cycle, since each enabled edge is a new boundary attempt.
- Latency: count reflects load/en action one cycle after the edge at which the inputs were sampled. No combinational path from inputs to count or tc.
- Arithmetic is unsigned, WIDTH bits. The internal next-count must never compute values above MAX_VAL or below 0 (no natural 2**WIDTH overflow used for wrap unless MAX_VAL == 2**WIDTH-1, where both agree).
- Reset mid-count overrides load/en on the same edge. The next cycle resumes counting from 0 using the current inputs.
- Simultaneous load and en: load wins, no count step applied.
- Direction change takes effect on the next enabled edge; no dead cycle.

Decomposition:
- Package up_down_counter_pkg holds the mode constants MODE_WRAP = 0 and MODE_SAT = 1, used for SAT_MODE.
- No sub-module. Next-state logic is a single always block plus a registered tc. at_max/at_min are continuous assigns.
- Elaboration-time check: MAX_VAL within 1..2**WIDTH-1; $error otherwise.

Test Plan (WIDTH = 4, MAX_VAL = 9 unless noted):
1. reset = 1 for 2 cycles, en = 1 -> count = 0, tc = 0, at_min = 1 while and after reset held.
2. Wrap mode, up from 0, en = 1 for 11 cycles -> count 1..9, then 0 with tc = 1 for exactly one cycle, then 1; at_max high only at 9.
3. Wrap mode, down from 0, en = 1 -> count = 9 with tc = 1; next cycle count = 8, tc = 0.
4. SAT_MODE = 1, load 9 then up for 3 cycles -> count stays 9, tc = 1 each cycle; then up_down = 0 -> 8, tc = 0.
5. load = 1, load_val = 13 with en = 1 -> count = 9 (clamped), no step, tc = 0; then load_val = 4 -> count = 4.
6. Mid-count reset: count = 6, reset = 1 with load = 1 and load_val = 3 on the same edge -> count = 0; next edge with en = 1, up -> count = 1.
7. Default params (WIDTH = 4, MAX_VAL = 15), wrap mode, up at 15 -> 0 with tc = 1 (legacy-equivalent behaviour).

Source files
------------

// File: rtl/up_down_counter_pkg.sv
// Shared constants for the parametrised up/down counter.
// MODE_* values select the SAT_MODE behaviour at the count limits.
package up_down_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter: count enable, clamped parallel load,
// wrap or saturate at the limits, and a registered terminal-count pulse.
module up_down_counter_param
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(32'd1);

    if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_params
        $error("up_down_counter_param: MAX_VAL must lie in 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH-1:0] load_clamped_s;

    // A full-range modulus can never see an out-of-range load, so no comparator is built.
    if (MAX_VAL == 2**WIDTH - 1) begin : g_no_clamp
        assign load_clamped_s = load_val;
    end else begin : g_clamp
        assign load_clamped_s = (load_val > MAX_C) ? MAX_C : load_val;
    end

    // Next count and terminal-count flag; load outranks enable, reset handled in the register.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped_s;
        end else if (en) begin
            if (up_down) begin
                if (count_q == MAX_C) begin
                    count_d = (SAT_MODE == MODE_SAT) ? MAX_C : ZERO_C;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (count_q == ZERO_C) begin
                    count_d = (SAT_MODE == MODE_SAT) ? ZERO_C : MAX_C;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ZERO_C;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q == MAX_C);
    assign at_min = (count_q == ZERO_C);

endmodule : up_down_counter_param

// File: tb/tb_up_down_counter_param.sv
// Scoreboard bench: three counter configurations share one random/directed stimulus
// stream; a modulo-arithmetic reference model predicts each cycle's outputs.
module tb_up_down_counter_param;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       amax;
        logic       amin;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en, up_down, load;
    logic [3:0] load_val;

    logic [3:0] cnt_w9, cnt_s9, cnt_w15;
    logic       tc_w9, tc_s9, tc_w15;
    logic       amax_w9, amax_s9, amax_w15;
    logic       amin_w9, amin_s9, amin_w15;

    int total_cnt = 0;
    int pass_cnt  = 0;

    exp_t q_w9[$];
    exp_t q_s9[$];
    exp_t q_w15[$];

    int m_cnt[3];
    int m_max[3] = '{9, 9, 15};
    bit m_sat[3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(0)) dut_w9 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(cnt_w9), .tc(tc_w9), .at_max(amax_w9), .at_min(amin_w9));

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1)) dut_s9 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(cnt_s9), .tc(tc_s9), .at_max(amax_s9), .at_min(amin_s9));

    up_down_counter_param dut_w15 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(cnt_w15), .tc(tc_w15), .at_max(amax_w15), .at_min(amin_w15));

    // Reference: counting is arithmetic modulo (max+1) in wrap mode, clipped to [0,max] when saturating.
    function automatic void model(input int c, input int mx, input bit sat, input bit r,
                                  input bit ld, input int lv, input bit e, input bit ud,
                                  output int nc, output bit ntc);
        nc  = c;
        ntc = 1'b0;
        if (r) begin
            nc = 0;
        end else if (ld) begin
            nc = (lv > mx) ? mx : lv;
        end else if (e && ud) begin
            ntc = (c == mx);
            nc  = sat ? ((c == mx) ? mx : c + 1) : (c + 1) % (mx + 1);
        end else if (e) begin
            ntc = (c == 0);
            nc  = sat ? ((c == 0) ? 0 : c - 1) : (c + mx) % (mx + 1);
        end
    endfunction

    task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit ud);
        exp_t ex;
        int   nc;
        bit   ntc;
        @(negedge clk);
        #1;
        reset    = r;
        load     = ld;
        load_val = 4'(lv);
        en       = e;
        up_down  = ud;
        for (int k = 0; k < 3; k++) begin
            model(m_cnt[k], m_max[k], m_sat[k], r, ld, lv, e, ud, nc, ntc);
            m_cnt[k] = nc;
            ex.cnt   = 4'(nc);
            ex.tc    = ntc;
            ex.amax  = (nc == m_max[k]);
            ex.amin  = (nc == 0);
            if (k == 0) q_w9.push_back(ex);
            else if (k == 1) q_s9.push_back(ex);
            else q_w15.push_back(ex);
        end
    endtask

    task automatic check(input string name, input exp_t exp_v, input exp_t got_v);
        total_cnt++;
        if (exp_v === got_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s t=%0t got cnt=%0d tc=%b max=%b min=%b, expected cnt=%0d tc=%b max=%b min=%b",
                     name, $time, got_v.cnt, got_v.tc, got_v.amax, got_v.amin,
                     exp_v.cnt, exp_v.tc, exp_v.amax, exp_v.amin);
        end
    endtask

    // Monitor: every falling edge the DUTs present a settled output; compare against the oldest prediction.
    always @(negedge clk) begin
        if (q_w9.size() > 0)  check("wrap9",  q_w9.pop_front(),  {cnt_w9, tc_w9, amax_w9, amin_w9});
        if (q_s9.size() > 0)  check("sat9",   q_s9.pop_front(),  {cnt_s9, tc_s9, amax_s9, amin_s9});
        if (q_w15.size() > 0) check("wrap15", q_w15.pop_front(), {cnt_w15, tc_w15, amax_w15, amin_w15});
    end

    initial begin
        reset = 1'b1; en = 1'b1; up_down = 1'b1; load = 1'b0; load_val = 4'd0;
        m_cnt = '{0, 0, 0};

        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 9, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 13, 1, 1);
        step(0, 1, 4, 1, 0);
        step(0, 1, 6, 0, 1);
        step(1, 1, 3, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 15, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) == 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
                 ($urandom_range(3) != 0), $urandom_range(1) == 1);
        end

        for (int i = 0; i < 10 && (q_w9.size() + q_s9.size() + q_w15.size()) > 0; i++) @(negedge clk);
        if ((q_w9.size() + q_s9.size() + q_w15.size()) > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d predictions left, expected 0",
                     q_w9.size() + q_s9.size() + q_w15.size());
        end
        #2;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_up_down_counter_param
